ofifo_psum: RTL

- Output-side collector directly downstream of the systolic MAC array; consumes the per-column partial sums leaving the bottom row (each tile's out_s).
- Columns finish at different cycles because of the diagonal skew, so each column writes independently into its own circular FIFO.
- Rows are popped only when every column holds data, so the array's output is re-aligned into complete rows for the accumulation/SFP stage.

---
 rtl/ofifo_psum.sv | 87 ++++++++
 1 files changed

// File: rtl/ofifo_psum.sv
// Output collector for the systolic array: one circular FIFO per column absorbs the
// skewed bottom-row psums and pops them back out as complete, aligned rows.
module ofifo_psum #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [col*psum_bw-1:0] in,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_valid,
  output logic                   o_ready,
  output logic                   o_full,
  output logic                   o_overflow
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

  logic [col-1:0]         empty_s;
  logic [col-1:0]         full_s;
  logic [col-1:0]         push_s;
  logic [col*psum_bw-1:0] head_s;
  logic                   pop_s;
  logic                   drop_s;

  assign o_ready = &(~empty_s);
  assign o_full  = |full_s;
  assign pop_s   = rd & o_ready;
  // A pop in the same edge frees the slot, so a write to a full column survives it.
  assign drop_s  = |(wr & full_s & ~{col{pop_s}});

  for (genvar g = 0; g < col; g++) begin : g_col
    logic [psum_bw-1:0] mem_r [depth];
    logic [aw:0]        wr_ptr_r;
    logic [aw:0]        rd_ptr_r;

    assign empty_s[g] = (wr_ptr_r == rd_ptr_r);
    assign full_s[g]  = (wr_ptr_r[aw-1:0] == rd_ptr_r[aw-1:0]) &&
                        (wr_ptr_r[aw] != rd_ptr_r[aw]);
    assign push_s[g]  = wr[g] & (~full_s[g] | pop_s);
    assign head_s[g*psum_bw +: psum_bw] = mem_r[rd_ptr_r[aw-1:0]];

    // Column pointer update; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (push_s[g]) begin
          wr_ptr_r <= wr_ptr_r + ptr_one;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + ptr_one;
        end
      end
    end

    // Column storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
      if (push_s[g]) begin
        mem_r[wr_ptr_r[aw-1:0]] <= in[g*psum_bw +: psum_bw];
      end
    end
  end

  // Registered row output, pop strobe and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      out        <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= pop_s;
      if (pop_s) begin
        out <= head_s;
      end
      if (drop_s) begin
        o_overflow <= 1'b1;
      end
    end
  end

endmodule
